taxi_eth_phy_10g_rx_ber_mon_mlane: RTL and testbench

Multi-lane 64b/66b sync-header BER monitor for multi-lane PCS receive paths (e.g. 40G/100G) and for banks of 10G ports. Each lane runs its own 125 us window and sets a high-BER flag at a programmable error threshold. The flag clears only after a programmable number of consecutive clean windows. Each lane also keeps a saturating error counter, and the block drives an OR-reduced alarm to the link-status logic.

---
 rtl/taxi_eth_phy_10g_rx_ber_mon_mlane.sv | 160 ++++++++++++++++
 tb/tb_taxi_eth_phy_10g_rx_ber_mon_mlane.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_eth_phy_10g_rx_ber_mon_mlane.sv
// -----------------------------------------------------------------------------
// taxi_eth_phy_10g_rx_ber_mon_mlane
//
// Multi-lane 64b/66b sync-header bit-error-rate monitor. Every lane runs its
// own ~125 us observation window. A lane raises its high-BER flag when
// BER_THRESH invalid sync headers arrive in one window. The flag drops again
// only after CLR_WINDOWS consecutive clean windows. A saturating per-lane
// counter accumulates every invalid header for statistics.
//
// Ports:
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   lane_en              per-lane enable; a disabled lane is held in reset
//                        (its error counter is held, not cleared)
//   serdes_rx_hdr        sync headers, lane l at [l*HDR_W +: HDR_W]
//   serdes_rx_hdr_valid  per-lane header qualifier
//   stat_clr             single-cycle pulse, zeroes all error counters
//   rx_high_ber          per-lane high-BER flag (registered)
//   rx_high_ber_any      OR of rx_high_ber (no added latency)
//   stat_err_cnt         per-lane saturating invalid-header count,
//                        lane l at [l*ERR_CNT_W +: ERR_CNT_W]
// -----------------------------------------------------------------------------
module taxi_eth_phy_10g_rx_ber_mon_mlane #(
    parameter int  LANES       = 4,
    parameter int  HDR_W       = 2,
    parameter real COUNT_125US = 125000/6.4,
    parameter int  BER_THRESH  = 16,
    parameter int  CLR_WINDOWS = 1,
    parameter int  ERR_CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANES-1:0]           lane_en,
    input  logic [LANES*HDR_W-1:0]     serdes_rx_hdr,
    input  logic [LANES-1:0]           serdes_rx_hdr_valid,
    input  logic                       stat_clr,
    output logic [LANES-1:0]           rx_high_ber,
    output logic                       rx_high_ber_any,
    output logic [LANES*ERR_CNT_W-1:0] stat_err_cnt
);

    // Only the integer part of the window length is meaningful in cycles.
    localparam int COUNT_125US_INT = $rtoi(COUNT_125US);
    localparam int TIMER_W         = $clog2(COUNT_125US_INT + 1);
    localparam int BER_W           = $clog2(BER_THRESH);
    localparam int CLEAN_W         = $clog2(CLR_WINDOWS + 1);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(COUNT_125US_INT);
    localparam logic [BER_W-1:0]   BER_LAST   = BER_W'(BER_THRESH - 1);
    localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLR_WINDOWS - 1);

    if (HDR_W != 2) begin : g_bad_hdr_w
        $fatal(1, "taxi_eth_phy_10g_rx_ber_mon_mlane: HDR_W must be 2");
    end

    if (BER_THRESH < 2) begin : g_bad_thresh
        $fatal(1, "taxi_eth_phy_10g_rx_ber_mon_mlane: BER_THRESH must be >= 2");
    end

    if (CLR_WINDOWS < 1) begin : g_bad_clr
        $fatal(1, "taxi_eth_phy_10g_rx_ber_mon_mlane: CLR_WINDOWS must be >= 1");
    end

    // 2'b00 and 2'b11 are not legal 64b/66b sync headers.
    function automatic logic hdr_invalid(input logic [HDR_W-1:0] h);
        return h[0] == h[1];
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [HDR_W-1:0]     hdr;
        logic                 hdr_vld;
        logic                 hdr_bad;
        logic                 set_ev;
        logic                 expiry;
        logic                 win_clean;
        logic [TIMER_W-1:0]   timer;
        logic [BER_W-1:0]     ber_cnt;
        logic [CLEAN_W-1:0]   clean_cnt;
        logic                 high_ber;
        logic [ERR_CNT_W-1:0] err_cnt;

        assign hdr       = serdes_rx_hdr[l*HDR_W +: HDR_W];
        // A disabled lane ignores its headers entirely.
        assign hdr_vld   = lane_en[l] & serdes_rx_hdr_valid[l];
        assign hdr_bad   = hdr_vld & hdr_invalid(hdr);
        // ber_cnt parks at BER_THRESH-1, so every further bad header in the
        // same window is also a set event.
        assign set_ev    = hdr_bad & (ber_cnt == BER_LAST);
        // The window only closes on a qualified header; the timer waits at 0.
        assign expiry    = hdr_vld & (timer == '0);
        assign win_clean = ber_cnt != BER_LAST;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                timer     <= TIMER_LOAD;
                ber_cnt   <= '0;
                clean_cnt <= '0;
                high_ber  <= 1'b0;
            end else if (!lane_en[l]) begin
                timer     <= TIMER_LOAD;
                ber_cnt   <= '0;
                clean_cnt <= '0;
                high_ber  <= 1'b0;
            end else begin
                // Window timing; expiry discards the expiry-cycle header count.
                if (expiry) begin
                    timer   <= TIMER_LOAD;
                    ber_cnt <= '0;
                end else begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end
                    if (hdr_bad && (ber_cnt != BER_LAST)) begin
                        ber_cnt <= ber_cnt + 1'b1;
                    end
                end

                // Flag and hysteresis: a set always wins over a clear, and a
                // set anywhere in a window abandons clear progress.
                if (set_ev) begin
                    high_ber  <= 1'b1;
                    clean_cnt <= '0;
                end else if (expiry) begin
                    if (win_clean && high_ber) begin
                        if (clean_cnt == CLEAN_LAST) begin
                            high_ber  <= 1'b0;
                            clean_cnt <= '0;
                        end else begin
                            clean_cnt <= clean_cnt + 1'b1;
                        end
                    end else begin
                        clean_cnt <= '0;
                    end
                end
            end
        end

        // Statistics survive lane disable; stat_clr takes priority but the
        // coincident bad header still counts.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_cnt <= '0;
            end else if (stat_clr) begin
                err_cnt <= ERR_CNT_W'(hdr_bad);
            end else if (hdr_bad) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end

        assign rx_high_ber[l]                           = high_ber;
        assign stat_err_cnt[l*ERR_CNT_W +: ERR_CNT_W]   = err_cnt;
    end

    assign rx_high_ber_any = |rx_high_ber;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_ber_mon_mlane.sv
module tb_taxi_eth_phy_10g_rx_ber_mon_mlane;

    localparam int LANES = 4;
    localparam int CNT   = 100;
    localparam int TH    = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  lane_en;
    logic [7:0]  hdr;
    logic [3:0]  hv;
    logic        stat_clr;
    logic [3:0]  hb0, hb1;
    logic        any0, any1;
    logic [63:0] ec0;
    logic [15:0] ec1;

    always #5 clk = ~clk;

    // dut0: CLR_WINDOWS=1, 16-bit counters; dut1: CLR_WINDOWS=3, 4-bit counters
    taxi_eth_phy_10g_rx_ber_mon_mlane #(
        .LANES(4), .HDR_W(2), .COUNT_125US(100.0), .BER_THRESH(TH),
        .CLR_WINDOWS(1), .ERR_CNT_W(16)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .lane_en(lane_en), .serdes_rx_hdr(hdr),
        .serdes_rx_hdr_valid(hv), .stat_clr(stat_clr), .rx_high_ber(hb0),
        .rx_high_ber_any(any0), .stat_err_cnt(ec0)
    );

    taxi_eth_phy_10g_rx_ber_mon_mlane #(
        .LANES(4), .HDR_W(2), .COUNT_125US(100.0), .BER_THRESH(TH),
        .CLR_WINDOWS(3), .ERR_CNT_W(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .lane_en(lane_en), .serdes_rx_hdr(hdr),
        .serdes_rx_hdr_valid(hv), .stat_clr(stat_clr), .rx_high_ber(hb1),
        .rx_high_ber_any(any1), .stat_err_cnt(ec1)
    );

    int total = 0;
    int bad   = 0;
    int k     = 0;   // clock edges since the last reset release

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // ---------------- reference model ----------------
    // Window tracked as "cycles left"; errors tracked as an unbounded count of
    // bad headers seen in the current window.
    int m_left [2][4];
    int m_errs [2][4];
    int m_flag [2][4];
    int m_clean[2][4];
    int m_stat [2][4];
    int clrw[2] = '{1, 3};
    int smax[2] = '{65535, 15};

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int l = 0; l < LANES; l++) begin
                m_left[d][l] = CNT; m_errs[d][l] = 0; m_flag[d][l] = 0;
                m_clean[d][l] = 0;  m_stat[d][l] = 0;
            end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++)
            for (int l = 0; l < LANES; l++) begin
                logic [1:0] h;
                bit v, inv, at_thresh, set, expw;
                h   = hdr[l*2 +: 2];
                v   = lane_en[l] && hv[l];
                inv = v && (h == 2'b00 || h == 2'b11);
                if (stat_clr) m_stat[d][l] = inv ? 1 : 0;
                else if (inv && m_stat[d][l] < smax[d]) m_stat[d][l]++;
                if (!lane_en[l]) begin
                    m_left[d][l] = CNT; m_errs[d][l] = 0;
                    m_flag[d][l] = 0;   m_clean[d][l] = 0;
                end else begin
                    at_thresh = m_errs[d][l] >= TH - 1;
                    set  = inv && at_thresh;
                    expw = v && m_left[d][l] == 0;
                    if (set) begin
                        m_flag[d][l] = 1; m_clean[d][l] = 0;
                    end else if (expw) begin
                        if (!at_thresh && m_flag[d][l] == 1) begin
                            m_clean[d][l]++;
                            if (m_clean[d][l] == clrw[d]) begin
                                m_flag[d][l] = 0; m_clean[d][l] = 0;
                            end
                        end else begin
                            m_clean[d][l] = 0;
                        end
                    end
                    if (expw) begin
                        m_left[d][l] = CNT; m_errs[d][l] = 0;
                    end else begin
                        if (m_left[d][l] > 0) m_left[d][l]--;
                        if (inv) m_errs[d][l]++;
                    end
                end
            end
    endtask

    function automatic logic [3:0] eflags(input int d);
        logic [3:0] f = '0;
        for (int l = 0; l < LANES; l++) f[l] = m_flag[d][l] != 0;
        return f;
    endfunction

    task automatic cmp_all(input string tag);
        logic [63:0] e0, e1;
        int s;
        e0 = '0; e1 = '0;
        for (int l = 0; l < LANES; l++) begin
            s = m_stat[0][l]; e0[l*16 +: 16] = s[15:0];
            s = m_stat[1][l]; e1[l*4 +: 4]   = s[3:0];
        end
        check_eq({tag, "_flag0"}, hb0, eflags(0));
        check_eq({tag, "_any0"}, any0, |eflags(0));
        check_eq({tag, "_cnt0"}, ec0, e0);
        check_eq({tag, "_flag1"}, hb1, eflags(1));
        check_eq({tag, "_any1"}, any1, |eflags(1));
        check_eq({tag, "_cnt1"}, ec1, e1);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        k++;
        cmp_all("cyc");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        cmp_all("rst");
        rst_n = 1'b1;
        k = 0;
    endtask

    function automatic logic [1:0] good_hdr();
        return $urandom_range(0, 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return $urandom_range(0, 1) ? 2'b00 : 2'b11;
    endfunction

    // all lanes valid with good headers, except lane 'bl' gets a bad header when 'b'
    task automatic drive(input int bl, input bit b);
        hv = 4'hF;
        for (int l = 0; l < LANES; l++)
            hdr[l*2 +: 2] = (l == bl && b) ? bad_hdr() : good_hdr();
    endtask

    int mode[4];
    logic [63:0] saved;

    initial begin
        rst_n = 1'b0; lane_en = 4'hF; hdr = '0; hv = '0; stat_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_flags0", hb0, 4'h0);
        check_eq("reset_cnt0", ec0, 64'h0);
        check_eq("reset_any1", any1, 1'b0);
        do_reset();

        // 16 bad headers on lane 0 in the first window
        for (int i = 0; i < 16; i++) begin drive(0, 1'b1); step(); end
        check_eq("t1_flag", hb0, 4'b0001);
        check_eq("t1_any", any0, 1'b1);
        check_eq("t1_cnt", ec0, 64'd16);

        // clean windows, then a 16-error window interrupting dut1's hysteresis
        while (k < 760) begin
            drive(0, k >= 310 && k <= 325);
            step();
            if (k == 305) check_eq("t2_clr1", {hb1[0], hb0[0]}, 2'b10);
            if (k == 330) check_eq("t2_reset", hb0[0], 1'b1);
            if (k == 650) check_eq("t2_hyst", hb1[0], 1'b1);
        end
        check_eq("t2_final", {hb1, hb0}, 8'h00);

        // 15 errors per window for 5 windows, then the 16th on an expiry cycle
        do_reset();
        while (k < 505) begin drive(0, (k % 101) < 15); step(); end
        check_eq("t3_noflag", hb0, 4'h0);
        check_eq("t3_cnt75", ec0[15:0], 16'd75);
        while (k < 606) begin drive(0, (k % 101) < 15 || k == 605); step(); end
        check_eq("t3_exp_set", hb0[0], 1'b1);

        // qualifier low with bad header values on the bus
        saved = ec0;
        hv = 4'h0; hdr = 8'h00;
        repeat (300) step();
        check_eq("t4_nocount", ec0, saved);
        repeat (5) begin drive(-1, 1'b0); step(); end

        // counter saturation and stat_clr priority on the 4-bit instance
        drive(-1, 1'b0); stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check_eq("t5_clr", ec1, 16'h0);
        repeat (20) begin drive(1, 1'b1); step(); end
        check_eq("t5_sat", ec1[7:4], 4'd15);
        drive(1, 1'b1); stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check_eq("t5_clr_hit", ec1[7:4], 4'd1);
        drive(-1, 1'b0); stat_clr = 1'b1; step(); stat_clr = 1'b0;
        check_eq("t5_clr_only", ec1[7:4], 4'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0)
                for (int l = 0; l < LANES; l++) mode[l] = $urandom_range(0, 3);
            for (int l = 0; l < LANES; l++) begin
                bit badh;
                case (mode[l])
                    0: badh = 1'b0;
                    1: badh = $urandom_range(0, 24) == 0;
                    2: badh = $urandom_range(0, 1) == 1;
                    default: badh = $urandom_range(0, 2) == 0;
                endcase
                hv[l] = (mode[l] == 3) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) != 0);
                hdr[l*2 +: 2] = badh ? bad_hdr() : good_hdr();
                if (lane_en[l]) begin
                    if ($urandom_range(0, 299) == 0) lane_en[l] = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    lane_en[l] = 1'b1;
                end
            end
            stat_clr = $urandom_range(0, 399) == 0;
            step();
        end
        stat_clr = 1'b0; lane_en = 4'hF;

        // lane disable and asynchronous reset
        do_reset();
        for (int i = 0; i < 16; i++) begin drive(2, 1'b1); step(); end
        check_eq("t6_flag", hb0, 4'b0100);
        lane_en[2] = 1'b0; drive(-1, 1'b0); step();
        check_eq("t6_dis_flag", hb0[2], 1'b0);
        check_eq("t6_dis_cnt", ec0[47:32], 16'd16);
        lane_en[2] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_arst_flags", {hb1, hb0}, 8'h00);
        check_eq("t6_arst_any", {any1, any0}, 2'b00);
        check_eq("t6_arst_cnt", {ec1, ec0}, 80'h0);
        model_reset();
        cmp_all("arst");
        @(negedge clk);
        rst_n = 1'b1; k = 0;
        repeat (5) begin drive(-1, 1'b0); step(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
